serial_bit_sampler: RTL and testbench

- Front-end stage that feeds the 0011 sequence detector.
- Conditions the raw slide-switch input: two-flop synchronizer, then debounce.
- Turns the conditioned level into a stream of discrete serial bits, each marked by a one-cycle strobe.
- Sampling is either on a slow periodic tick (auto mode) or on each debounced press of a step push-button (manual mode).

---
 rtl/serial_bit_sampler.sv | 170 +++++++++++++++++
 tb/tb_serial_bit_sampler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module   : serial_bit_sampler
// Purpose  : Synchronizes and debounces a data switch and a step button, then
//            samples the debounced data into a strobed serial bit stream,
//            either on a periodic tick (auto) or per button press (manual).
// Revision : 1.0 - initial release
// ============================================================================
module serial_bit_sampler #(
    parameter int TICK_DIV        = 20000000,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       x_raw,
    input  logic       step_raw,
    input  logic       mode,
    output logic       bit_out,
    output logic       bit_valid,
    output logic [3:0] history,
    output logic [7:0] sample_cnt,
    output logic       blinkled
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    // bit 0 = x, bit 1 = step, bit 2 = mode
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [1:0] w_db;       // current debounced levels (x, step)
    logic [1:0] w_db_next;  // level the debouncers hold after this edge
    logic       w_mode;
    logic       r_mode_prev;
    logic       w_mode_chg;
    logic [c_TICK_W-1:0] r_tick;
    logic       w_tick_wrap;
    state_t     r_state;
    state_t     w_state_next;
    logic       w_step_strobe;
    logic       w_strobe;

    assign w_raw = {mode, step_raw, x_raw};

    // Two-flop synchronizers for all three asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_db
            logic              r_level;
            logic [c_DB_W-1:0] r_cnt;

            // Count consecutive disagreeing cycles; adopt the new level once the run is long enough
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else if (r_sync2[i] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_level <= r_sync2[i];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_db[i]      = r_level;
            assign w_db_next[i] = ((r_sync2[i] != r_level) && (r_cnt == c_DB_LAST))
                                  ? r_sync2[i] : r_level;
        end
    endgenerate

    assign w_mode     = r_sync2[2];
    assign w_mode_chg = w_mode ^ r_mode_prev;

    // Remember last synchronized mode to detect mode changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_prev <= 1'b0;
        end else begin
            r_mode_prev <= w_mode;
        end
    end

    // Auto-mode tick counter; parked at zero in manual mode and on a mode change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= '0;
        end else if (w_mode || w_mode_chg || (r_tick == c_TICK_MAX)) begin
            r_tick <= '0;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    assign w_tick_wrap = !w_mode && !w_mode_chg && (r_tick == c_TICK_MAX);

    // Step FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Step FSM next state: one strobe per press; mode change re-aligns to the button without a strobe
    always_comb begin
        w_state_next  = r_state;
        w_step_strobe = 1'b0;
        if (w_mode_chg) begin
            w_state_next = w_db_next[1] ? ST_PRESSED : ST_IDLE;
        end else if (w_mode) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_db_next[1]) begin
                        w_state_next  = ST_PRESSED;
                        w_step_strobe = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_db_next[1]) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_strobe = w_tick_wrap | w_step_strobe;

    // Output registers: capture the debounced data bit and update history/count/LED on a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            history    <= 4'b0000;
            sample_cnt <= 8'd0;
            blinkled   <= 1'b0;
        end else begin
            bit_valid <= w_strobe;
            if (w_strobe) begin
                bit_out    <= w_db_next[0];
                history    <= {history[2:0], w_db_next[0]};
                sample_cnt <= sample_cnt + 8'd1;
                blinkled   <= ~blinkled;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_bit_sampler
// Purpose  : Self-checking bench for serial_bit_sampler with a behavioural
//            reference model and directed plus randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_bit_sampler;

    localparam int TICK_DIV        = 8;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int HIST_DEPTH      = 8192;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       x_raw = 1'b0;
    logic       step_raw = 1'b0;
    logic       mode = 1'b0;
    logic       bit_out;
    logic       bit_valid;
    logic [3:0] history;
    logic [7:0] sample_cnt;
    logic       blinkled;

    int checks = 0;
    int errors = 0;

    serial_bit_sampler #(
        .TICK_DIV        (TICK_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x_raw      (x_raw),
        .step_raw   (step_raw),
        .mode       (mode),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .history    (history),
        .sample_cnt (sample_cnt),
        .blinkled   (blinkled)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Raw inputs recorded per clock edge since the last reset; the value the
    // design "sees" at edge k is the raw value captured two edges earlier.
    bit rx [HIST_DEPTH];
    bit rs [HIST_DEPTH];
    bit rm [HIST_DEPTH];
    int mk = 0;
    int auto_run = 0;
    bit m_dbx = 0, m_dbs = 0, m_mprev = 0;
    bit m_bit = 0, m_valid = 0, m_blink = 0;
    logic [3:0] m_hist = 4'h0;
    logic [7:0] m_cnt = 8'h0;

    function automatic bit seen_at(input int which, input int k);
        int idx;
        idx = k - 2;
        if (idx < 1 || idx >= HIST_DEPTH) return 1'b0;
        case (which)
            0: return rx[idx];
            1: return rs[idx];
            default: return rm[idx];
        endcase
    endfunction

    // Level flips once the last DEBOUNCE_CYCLES seen values all disagree with it
    function automatic bit flips(input int which, input int k, input bit level);
        for (int i = 0; i < DEBOUNCE_CYCLES; i++)
            if (seen_at(which, k - i) == level) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit sm, chg, strobe, old_dbs;
        if (!rst_n) begin
            mk = 0; auto_run = 0;
            m_dbx = 0; m_dbs = 0; m_mprev = 0;
            m_bit = 0; m_valid = 0; m_blink = 0;
            m_hist = 4'h0; m_cnt = 8'h0;
        end else begin
            mk++;
            if (mk < HIST_DEPTH) begin
                rx[mk] = x_raw; rs[mk] = step_raw; rm[mk] = mode;
            end
            old_dbs = m_dbs;
            if (flips(0, mk, m_dbx)) m_dbx = !m_dbx;
            if (flips(1, mk, m_dbs)) m_dbs = !m_dbs;
            sm = seen_at(2, mk);
            chg = (sm != m_mprev);
            m_mprev = sm;
            strobe = 1'b0;
            if (chg || sm) begin
                auto_run = 0;
            end else begin
                auto_run++;
                if (auto_run % TICK_DIV == 0) strobe = 1'b1;
            end
            if (sm && !chg && m_dbs && !old_dbs) strobe = 1'b1;
            m_valid = strobe;
            if (strobe) begin
                m_bit = m_dbx;
                m_hist = {m_hist[2:0], m_dbx};
                m_cnt = m_cnt + 8'd1;
                m_blink = !m_blink;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #2;
        check("bit_valid",  {7'd0, bit_valid}, {7'd0, m_valid});
        check("bit_out",    {7'd0, bit_out},   {7'd0, m_bit});
        check("history",    {4'd0, history},   {4'd0, m_hist});
        check("sample_cnt", sample_cnt,        m_cnt);
        check("blinkled",   {7'd0, blinkled},  {7'd0, m_blink});
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_bit_out",    {7'd0, bit_out},   8'd0);
        check("rst_bit_valid",  {7'd0, bit_valid}, 8'd0);
        check("rst_history",    {4'd0, history},   8'd0);
        check("rst_sample_cnt", sample_cnt,        8'd0);
        check("rst_blinkled",   {7'd0, blinkled},  8'd0);
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Auto mode, data held high from release
        x_raw = 1'b1; mode = 1'b0; step_raw = 1'b0;
        do_reset();
        cyc(7);
        check("t1_no_early_strobe", {7'd0, bit_valid}, 8'd0);
        cyc(1);
        check("t1_first_strobe", {7'd0, bit_valid}, 8'd1);
        check("t1_first_bit",    {7'd0, bit_out},   8'd1);
        cyc(24);
        check("t1_history", {4'd0, history}, 8'h0F);
        check("t1_cnt",     sample_cnt,      8'd4);

        // Short glitch on a stable 0 never reaches the debounced level
        x_raw = 1'b0;
        do_reset();
        cyc(10);
        x_raw = 1'b1; cyc(3); x_raw = 1'b0;
        cyc(30);
        check("t2_history", {4'd0, history}, 8'h00);
        check("t2_bit",     {7'd0, bit_out}, 8'd0);

        // Data 0,0,1,1 changing a full tick ahead of each strobe
        x_raw = 1'b0;
        do_reset();
        cyc(16);
        x_raw = 1'b1;
        cyc(16);
        check("t3_history", {4'd0, history},   8'h03);
        check("t3_blink",   {7'd0, blinkled},  8'd0);
        check("t3_cnt",     sample_cnt,        8'd4);

        // Manual mode: held button gives one strobe, second press gives another
        mode = 1'b1; x_raw = 1'b1; step_raw = 1'b0;
        do_reset();
        cyc(20);
        step_raw = 1'b1;
        cyc(5);
        check("t4_no_early_step", {7'd0, bit_valid}, 8'd0);
        cyc(1);
        check("t4_step_strobe", {7'd0, bit_valid}, 8'd1);
        cyc(44);
        check("t4_held_once", sample_cnt, 8'd1);
        step_raw = 1'b0; cyc(20);
        step_raw = 1'b1; cyc(20);
        check("t4_cnt", sample_cnt, 8'd2);
        step_raw = 1'b0;

        // Switch to manual while the button is already held and debounced
        mode = 1'b0; x_raw = 1'b0; step_raw = 1'b0;
        do_reset();
        cyc(5);
        step_raw = 1'b1;
        cyc(12);
        mode = 1'b1;
        cyc(30);
        check("t5_no_phantom", sample_cnt, 8'd2);
        step_raw = 1'b0; cyc(10);
        step_raw = 1'b1; cyc(10);
        check("t5_new_press", sample_cnt, 8'd3);
        step_raw = 1'b0;

        // Reset mid-tick, then run to counter wrap
        mode = 1'b0; x_raw = 1'b1;
        do_reset();
        cyc(29);
        check("t6_pre_cnt", sample_cnt, 8'd3);
        do_reset();
        cyc(7);
        check("t6_no_early", {7'd0, bit_valid}, 8'd0);
        cyc(1);
        check("t6_full_period", {7'd0, bit_valid}, 8'd1);
        cyc(256 * TICK_DIV);
        check("t6_wrap", sample_cnt, 8'd1);

        // Randomized inputs, checked every cycle by the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5, 0) == 0)   x_raw    = ~x_raw;
            if ($urandom_range(7, 0) == 0)   step_raw = ~step_raw;
            if ($urandom_range(299, 0) == 0) mode     = ~mode;
            cyc(1);
        end

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
